// File: rtl/ibuf_ctt_rx.sv
// ibuf_ctt_rx -- receive side of a shared CTT tri-state bus.
// Synchronises the pad level, waits out a bus-turnaround guard after the
// local driver releases the bus, then tracks the remote level on O with
// edge (RISE/FALL) and abandoned-change (GLITCH) pulses.
// Build option: define IBUF_CTT_RX_FILTER_EN to require FILTER_LEN stable
// samples before O follows the bus; without it O follows the first
// differing sample and GLITCH is tied low.
module ibuf_ctt_rx #(
  parameter int FILTER_LEN = 3,  // stable samples to accept a level, 1..15
  parameter int TURN_CYC   = 2   // turnaround guard cycles, 0..15
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic I,
  input  logic T,
  input  logic GTS,
  output logic O,
  output logic VALID,
  output logic RISE,
  output logic FALL,
  output logic GLITCH
);

  typedef enum logic [1:0] {
    DRIVE = 2'd0,
    TURN  = 2'd1,
    RECV  = 2'd2
  } state_t;

  localparam logic [3:0] L_TURN = 4'(TURN_CYC);

  // Out-of-range parameters stop elaboration instead of silently wrapping
  // the 4-bit counters.
  if (FILTER_LEN < 1 || FILTER_LEN > 15 || TURN_CYC < 0 || TURN_CYC > 15) begin : g_bad_param
    $error("ibuf_ctt_rx: FILTER_LEN must be 1..15 and TURN_CYC 0..15");
  end

  state_t     r_state;
  logic [3:0] r_tcnt;
  logic       r_s1;
  logic       r_s2;
  logic       r_o;
  logic       r_valid;
  logic       r_rise;
  logic       r_fall;

  logic       w_rx_mode;
  logic       w_recv;
  logic       w_take;

  // The local driver is off when either the local or the global tri-state
  // control says so; only then can a remote driver own the bus.
  assign w_rx_mode = T | GTS;
  assign w_recv    = w_rx_mode && (r_state == RECV);

`ifdef IBUF_CTT_RX_FILTER_EN
  localparam logic [3:0] L_FILT_LAST = 4'(FILTER_LEN - 1);

  logic [3:0] r_fcnt;
  logic       r_glitch;

  // O moves on the edge where the FILTER_LEN-th consecutive differing
  // sample is seen.
  assign w_take = w_recv && (r_s2 != r_o) && (r_fcnt == L_FILT_LAST);

  // Filter count: run while the sample disagrees with O, flag an abandoned
  // change, and drop silently whenever we are not receiving.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fcnt   <= 4'd0;
      r_glitch <= 1'b0;
    end else begin
      r_glitch <= 1'b0;
      if (!w_recv) begin
        r_fcnt <= 4'd0;
      end else if (r_s2 != r_o) begin
        r_fcnt <= w_take ? 4'd0 : r_fcnt + 4'd1;
      end else begin
        r_fcnt   <= 4'd0;
        r_glitch <= (r_fcnt != 4'd0);
      end
    end
  end

  assign GLITCH = r_glitch;
`else
  assign w_take = w_recv && (r_s2 != r_o);
  assign GLITCH = 1'b0;
`endif

  // Synchroniser, turnaround FSM and registered receive outputs.
  // NOTE: every register here uses non-blocking assignment so all flops
  // sample pre-edge values; r_s2 <= r_s1 then forms a true two-stage chain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= TURN;
      r_tcnt  <= L_TURN;
      r_o     <= 1'b0;
      r_valid <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1   <= I;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_rx_mode) begin
        // Local driver owns the bus: hold O, nothing to receive.
        r_state <= DRIVE;
        r_valid <= 1'b0;
      end else begin
        unique case (r_state)
          DRIVE: begin
            if (L_TURN == 4'd0) begin
              r_state <= RECV;
              r_valid <= 1'b1;
              r_o     <= r_s2;
            end else begin
              r_state <= TURN;
              r_tcnt  <= L_TURN;
            end
          end
          TURN: begin
            if (r_tcnt <= 4'd1) begin
              // Entry load is a resync, not an edge: no RISE/FALL here.
              r_state <= RECV;
              r_valid <= 1'b1;
              r_o     <= r_s2;
            end else begin
              r_tcnt <= r_tcnt - 4'd1;
            end
          end
          RECV: begin
            if (w_take) begin
              r_o    <= r_s2;
              r_rise <= r_s2;
              r_fall <= ~r_s2;
            end
          end
          default: begin
            r_state <= DRIVE;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign O     = r_o;
  assign VALID = r_valid;
  assign RISE  = r_rise;
  assign FALL  = r_fall;

endmodule

// File: tb/tb_ibuf_ctt_rx.sv
// tb_ibuf_ctt_rx -- scoreboard bench for ibuf_ctt_rx (FILTER_LEN=3,
// TURN_CYC=2). Stimulus pushes the expected output events with the edge
// number they must appear on; a monitor detects VALID edges and
// RISE/FALL/GLITCH pulses and pops/compares them. Expectations follow the
// build: IBUF_CTT_RX_FILTER_EN defined or not.
module tb_ibuf_ctt_rx;

  localparam int FL = 3;
  localparam int TC = 2;
`ifdef IBUF_CTT_RX_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = 2 + FL;   // pad change to O change
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = 3;
`endif

  typedef enum int {EV_VUP, EV_VDN, EV_RISE, EV_FALL, EV_GLITCH} ev_kind_t;

  typedef struct {
    ev_kind_t kind;
    int       cyc;
    logic     o;
  } ev_t;

  logic CLK;
  logic RST_N;
  logic I;
  logic T;
  logic GTS;
  logic O;
  logic VALID;
  logic RISE;
  logic FALL;
  logic GLITCH;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_valid = 1'b0;

  ibuf_ctt_rx #(
    .FILTER_LEN(FL),
    .TURN_CYC  (TC)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .I     (I),
    .T     (T),
    .GTS   (GTS),
    .O     (O),
    .VALID (VALID),
    .RISE  (RISE),
    .FALL  (FALL),
    .GLITCH(GLITCH)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edge counter: after posedge k, cyc == k.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_t kind, input int at, input logic o);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.o    = o;
    exp_q.push_back(e);
  endtask

  task automatic detect(input ev_kind_t kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d, required none", int'(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", int'(kind), int'(e.kind));
      check("ev_cycle", cyc, e.cyc);
      check("ev_o", int'(O), int'(e.o));
      check("rise_fall_excl", int'(RISE & FALL), 0);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    if (VALID !== prev_valid) detect(VALID ? EV_VUP : EV_VDN);
    prev_valid = VALID;
    if (RISE)   detect(EV_RISE);
    if (FALL)   detect(EV_FALL);
    if (GLITCH) detect(EV_GLITCH);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int n;
    I     = 1'b0;
    T     = 1'b1;
    GTS   = 1'b0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    cycles(3);

    // Reset state.
    check("rst_o", int'(O), 0);
    check("rst_valid", int'(VALID), 0);
    check("rst_rise", int'(RISE), 0);
    check("rst_fall", int'(FALL), 0);
    check("rst_glitch", int'(GLITCH), 0);

    // Reset release: TURN counter starts at TURN_CYC, RECV on 2nd edge.
    RST_N = 1'b1;
    expect_ev(EV_VUP, cyc + 2, 1'b0);
    cycles(6);

    // Clean rising level.
    I = 1'b1;
    expect_ev(EV_RISE, cyc + LAT, 1'b1);
    cycles(8);

    // Clean falling level.
    I = 1'b0;
    expect_ev(EV_FALL, cyc + LAT, 1'b0);
    cycles(8);

    // Two-cycle pulse: abandoned at count 2 when filtered.
    n = cyc;
    I = 1'b1;
    if (FILT) begin
      expect_ev(EV_GLITCH, n + 5, 1'b0);
    end else begin
      expect_ev(EV_RISE, n + 3, 1'b1);
      expect_ev(EV_FALL, n + 5, 1'b0);
    end
    cycles(2);
    I = 1'b0;
    cycles(8);

    // One-cycle pulse.
    n = cyc;
    I = 1'b1;
    if (FILT) begin
      expect_ev(EV_GLITCH, n + 4, 1'b0);
    end else begin
      expect_ev(EV_RISE, n + 3, 1'b1);
      expect_ev(EV_FALL, n + 4, 1'b0);
    end
    cycles(1);
    I = 1'b0;
    cycles(8);

    // Local driver retakes the bus with a change pending: no GLITCH.
    n = cyc;
    I = 1'b1;
    if (!FILT) expect_ev(EV_RISE, n + 3, 1'b1);
    cycles(4);
    T = 1'b0;
    expect_ev(EV_VDN, n + 5, FILT ? 1'b0 : 1'b1);
    cycles(4);
    check("drive_o_held", int'(O), FILT ? 0 : 1);
    check("drive_valid", int'(VALID), 0);
    T = 1'b1;
    expect_ev(EV_VUP, cyc + 3, 1'b1);
    cycles(6);

    // GTS alone releases the bus.
    T = 1'b0;
    expect_ev(EV_VDN, cyc + 1, 1'b1);
    I = 1'b0;
    cycles(4);
    check("gts_pre_valid", int'(VALID), 0);
    GTS = 1'b1;
    expect_ev(EV_VUP, cyc + 3, 1'b0);
    cycles(6);
    T   = 1'b1;
    GTS = 1'b0;
    cycles(4);
    check("rx_mode_held_valid", int'(VALID), 1);

    // Reset mid-filter discards the pending change.
    n = cyc;
    I = 1'b1;
    if (!FILT) expect_ev(EV_RISE, n + 3, 1'b1);
    cycles(3);
    #1 RST_N = 1'b0;
    expect_ev(EV_VDN, n + 4, 1'b0);
    cycles(2);
    check("midrst_o", int'(O), 0);
    check("midrst_valid", int'(VALID), 0);
    RST_N = 1'b1;
    expect_ev(EV_VUP, cyc + 2, 1'b0);
    expect_ev(EV_RISE, cyc + LAT, 1'b1);
    cycles(12);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibuf_ctt_rx.md
IBUF_CTT_RX -- requirements
Module: ibuf_ctt_rx

Interface
REQ-001 SHALL provide parameter FILTER_LEN, default 3: consecutive stable samples required to accept a new bus level (legal 1..15).
REQ-002 SHALL provide parameter TURN_CYC, default 2: guard cycles after the local driver releases the bus before receiving (legal 0..15).
REQ-003 SHALL provide port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL provide port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port I  input  1  pad level of the shared CTT tri-state bus, asynchronous to CLK.
REQ-006 SHALL provide port T  input  1  local tri-state control, same meaning as the transmit buffer (1 = local driver off).
REQ-007 SHALL provide port GTS  input  1  global tri-state (1 = all drivers forced off).
REQ-008 SHALL provide port O  output  1  filtered received bus level.
REQ-009 SHALL provide port VALID  output  1  high while in RECV state; O reflects the remote driver.
REQ-010 SHALL provide port RISE  output  1  one-cycle pulse on each O 0->1 transition.
REQ-011 SHALL provide port FALL  output  1  one-cycle pulse on each O 1->0 transition.
REQ-012 SHALL provide port GLITCH  output  1  one-cycle pulse when a pending level change is abandoned.

Function
REQ-013 SHALL synchronise I through two flops (s1, s2); s2 is the only sampled bus value.
REQ-014 SHALL define rx_mode = T OR GTS, evaluated each cycle.
REQ-015 SHALL implement states DRIVE, TURN, RECV with next-state priority: rx_mode=0 -> DRIVE from any state.
REQ-016 SHALL, in DRIVE with rx_mode=1, go to TURN and load turn counter with TURN_CYC; if TURN_CYC=0, go directly to RECV.
REQ-017 SHALL, in TURN, decrement the counter each cycle and enter RECV on the cycle the counter would reach 0.
REQ-018 SHALL, on entry to RECV, load O with s2, without RISE/FALL pulses, and clear the filter count.
REQ-019 SHALL, in RECV, increment filter count each cycle s2 != O; when count reaches FILTER_LEN, update O to s2 and clear count in the same edge.
REQ-020 SHALL, in RECV, clear filter count when s2 == O; if count was nonzero, pulse GLITCH for one cycle.
REQ-021 SHALL pulse RISE/FALL in the cycle following the edge that updates O; never both simultaneously.
REQ-022 SHALL hold O and clear filter count in DRIVE and TURN; RISE, FALL and GLITCH are 0 there.
REQ-023 SHALL give latency from stable pad change to O change of 2 + FILTER_LEN cycles in RECV.
REQ-024 SHALL abort any pending filter count, without GLITCH, when rx_mode drops mid-count.
REQ-025 SHALL saturate no counter beyond 4 bits; parameter values outside legal ranges are illegal.

Reset
REQ-026 SHALL, on RST_N low, asynchronously set s1=s2=0, O=0, VALID=0, RISE=FALL=GLITCH=0, filter count 0, state TURN, turn counter TURN_CYC.
REQ-027 SHALL leave reset synchronously on the first CLK edge with RST_N high; a reset mid-filter discards the pending change.

Configuration
REQ-028 SHALL compile the glitch filter only when macro IBUF_CTT_RX_FILTER_EN is defined.
REQ-029 SHALL, with IBUF_CTT_RX_FILTER_EN defined, behave per REQ-019/REQ-020.
REQ-030 SHALL, without IBUF_CTT_RX_FILTER_EN, ignore FILTER_LEN, update O from s2 on the first differing cycle (latency 3), and tie GLITCH to 0.

Verification
REQ-031 SHALL cover: reset, T=1, GTS=0, TURN_CYC=2 -> VALID rises on 2nd edge after reset release, O=s2, no RISE.
REQ-032 SHALL cover: RECV, FILTER_LEN=3, I 0->1 held -> O=1 exactly 5 cycles later, RISE one cycle.
REQ-033 SHALL cover: RECV, FILTER_LEN=3, I high for 2 cycles then low -> O stays 0, single GLITCH pulse (filter build).
REQ-034 SHALL cover: T=1->0 with count=2 pending -> DRIVE next cycle, VALID=0, O held, no GLITCH; T back to 1 -> VALID after TURN_CYC cycles.
REQ-035 SHALL cover: GTS=1 with T=0 -> behaves as rx_mode=1, VALID after TURN_CYC cycles.
REQ-036 SHALL cover: filter macro undefined, I 1->0 -> O=0 after 3 cycles, FALL pulse, GLITCH never asserted.
